lockstep_tcdm_pair_ctrl: RTL
============================

# lockstep_tcdm_pair_ctrl

- Parametrised successor of the fixed 8-core lockstep TCDM shim.
- Pairs cores (2p = master, 2p+1 = checker) on the core-to-TCDM-interconnect boundary.
- Each pair is switched independently between split and lockstep mode with a safe drain handshake.
- In lockstep mode the block compares the two request streams, forwards one, broadcasts responses, and latches a fault with a saturating error count.

## Interface
- N_CORES, 8: cores on the boundary; even; N_PAIRS = N_CORES/2.
- ADDR_WIDTH, 32: TCDM address width.
- DATA_WIDTH, 32: TCDM data width; BE_WIDTH = DATA_WIDTH/8.
- MAX_OUTSTANDING, 4: max in-flight requests per lane; ≥1.
- ERR_CNT_WIDTH, 8: per-pair error counter width.

Ports:
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  asynchronous, active-high reset.
- lockstep_req_i  in  N_PAIRS  per pair: 1 requests lockstep mode, 0 requests split mode.
- fault_clr_i  in  N_PAIRS  per pair: clears a latched fault.
- lockstep_active_o  out  N_PAIRS  pair is in LOCKED.
- fault_o  out  N_PAIRS  pair is in FAULT.
- err_cnt_o  out  N_PAIRS*ERR_CNT_WIDTH  saturating mismatch count.
- core_req_i / core_wen_i  in  N_CORES each  core request and write-enable (wen=0 means write).
- core_add_i  in  N_CORES*ADDR_WIDTH  core address.
- core_wdata_i  in  N_CORES*DATA_WIDTH  core write data.
- core_be_i  in  N_CORES*BE_WIDTH  core byte enables.
- core_gnt_o / core_r_valid_o  out  N_CORES each  grant and response-valid to cores.
- core_r_rdata_o  out  N_CORES*DATA_WIDTH  response data to cores.
- ic_req_o / ic_wen_o / ic_add_o / ic_wdata_o / ic_be_o  out  same widths as core side  requests to interconnect.
- ic_gnt_i / ic_r_valid_i  in  N_CORES each  interconnect grant and response-valid.
- ic_r_rdata_i  in  N_CORES*DATA_WIDTH  interconnect response data.

## Operation
- Per-lane outstanding counter, width $clog2(MAX_OUTSTANDING+1):
  - +1 on ic_req_o&ic_gnt_i; −1 on ic_r_valid_i; both in the same cycle leave it unchanged.
  - ic_r_valid_i at count 0 is ignored and flagged by a simulation assertion.
  - At count == MAX_OUTSTANDING, that lane's ic_req_o is forced to 0 in every state.
- ic_add/wen/wdata/be always follow the lane's own core; only req, gnt and response routing change.
- Per-pair FSM, states SPLIT, DRAIN, LOCKED, FAULT:
  - SPLIT: both lanes pass through. lockstep_req_i=1 → DRAIN.
  - DRAIN: ic_req_o=0 and core_gnt_o=0 on both lanes; responses still delivered. When both counters are 0: → LOCKED if lockstep_req_i=1, else → SPLIT.
  - LOCKED: on entry the bcast flag is set.
    - Checker ic_req_o=0. Master ic_req_o = req_m & req_c & !mismatch.
    - core_gnt_o of both cores = master ic_gnt_i gated by the same condition.
    - Mismatch: req_m≠req_c, or both requesting and add, wen or be differ, or wdata differs on a write (wen=0).
    - Mismatch → FAULT, err_cnt +1 saturating. lockstep_req_i=0 → DRAIN. Mismatch has priority.
  - FAULT: no new requests from either lane; in-flight responses are still delivered. fault_clr_i=1 with both counters 0 → SPLIT. fault_clr_i is ignored while the counters are nonzero.
- bcast set: both cores receive the master lane r_valid/r_rdata, and checker lane ic_r_valid_i is ignored. bcast clears on the transition into SPLIT.
- Reset: state SPLIT, counters 0, bcast 0, err_cnt 0; all outputs 0 except pass-through data fields.

## Timing
- Request/grant path is combinational, zero added latency; responses pass through combinationally.
- FSM, counters, bcast and err_cnt are registered; a mismatch at cycle t suppresses the request at t, and fault_o=1 and err_cnt update at t+1.
- DRAIN→LOCKED occurs the cycle after the last response lowers both counters to 0. Minimum DRAIN dwell is 1 cycle.
- Assertion of rst_i mid-operation clears everything immediately (async); in-flight responses after release are ignored, counter stays 0.

## Structure
- Package lockstep_pkg: lockstep_state_e (SPLIT, DRAIN, LOCKED, FAULT).
- Sub-module lockstep_pair_ctrl, one per pair, holds:
  - the FSM,
  - the two outstanding counters,
  - bcast,
  - err_cnt,
  - the comparator.
- The top level generates N_PAIRS instances and slices the flat buses.

## Test plan
- SPLIT: core 3 write to 0x1000_0040, ic_gnt_i=1 → identical ic request on lane 3, core_gnt_o[3]=1, lockstep_active_o=0.
- Core 0 has 1 read outstanding, lockstep_req_i[0]=1 → DRAIN (gnt 0 to cores 0/1); rvalid arrives → lockstep_active_o[0]=1 next cycle.
- LOCKED, cores 0/1 read 0x1000_0100 → ic_req_o[1]=0, ic_req_o[0]=1, both gnt; rdata 0xDEADBEEF on lane 0 → delivered to cores 0 and 1.
- LOCKED writes with wdata 0x1 vs 0x2 → ic_req_o[0]=0, fault_o[0]=1 and err_cnt 1 next cycle; fault_clr_i → SPLIT.
- ERR_CNT_WIDTH=2, 5 fault/clear cycles → err_cnt_o stays 3.
- MAX_OUTSTANDING=2, rvalid withheld → third request sees ic_req_o=0, gnt=0; rst_i pulse mid-LOCKED → all reset values, lockstep_active_o=0.

Source files
------------

// File: rtl/lockstep_pkg.sv
// Shared types for the lockstep TCDM pair controller.
package lockstep_pkg;

    // Per-pair operating mode.
    typedef enum logic [1:0] {
        StSplit,
        StDrain,
        StLocked,
        StFault
    } lockstep_state_e;

endpackage

// File: rtl/lockstep_pair_ctrl.sv
// One core pair (lane 0 = master, lane 1 = checker): mode FSM, outstanding
// counters, response broadcast flag, request comparator and error counter.
module lockstep_pair_ctrl
    import lockstep_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned ERR_CNT_WIDTH   = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       lockstep_req_i,
    input  logic                       fault_clr_i,
    output logic                       lockstep_active_o,
    output logic                       fault_o,
    output logic [ERR_CNT_WIDTH-1:0]   err_cnt_o,
    input  logic [1:0]                 core_req_i,
    input  logic [1:0]                 core_wen_i,
    input  logic [2*ADDR_WIDTH-1:0]    core_add_i,
    input  logic [2*DATA_WIDTH-1:0]    core_wdata_i,
    input  logic [2*(DATA_WIDTH/8)-1:0] core_be_i,
    output logic [1:0]                 core_gnt_o,
    output logic [1:0]                 core_r_valid_o,
    output logic [2*DATA_WIDTH-1:0]    core_r_rdata_o,
    output logic [1:0]                 ic_req_o,
    input  logic [1:0]                 ic_gnt_i,
    input  logic [1:0]                 ic_r_valid_i,
    input  logic [2*DATA_WIDTH-1:0]    ic_r_rdata_i
);

    localparam int unsigned BeWidth  = DATA_WIDTH / 8;
    localparam int unsigned CntWidth = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CntWidth-1:0]      CntMax = CntWidth'(MAX_OUTSTANDING);
    localparam logic [CntWidth-1:0]      CntOne = CntWidth'(1);
    localparam logic [ERR_CNT_WIDTH-1:0] ErrMax = '1;
    localparam logic [ERR_CNT_WIDTH-1:0] ErrOne = ERR_CNT_WIDTH'(1);

    lockstep_state_e            state_q, state_d;
    logic [1:0][CntWidth-1:0]   cnt_q, cnt_d;
    logic                       bcast_q, bcast_d;
    logic [ERR_CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;
    logic [1:0]                 full, inc, dec;
    logic                       mismatch, pair_go;

    // Compare master and checker request streams.
    always_comb begin
        mismatch = 1'b0;
        if (core_req_i[0] != core_req_i[1]) begin
            mismatch = 1'b1;
        end else if (core_req_i[0]) begin
            if ((core_add_i[ADDR_WIDTH-1:0] != core_add_i[2*ADDR_WIDTH-1:ADDR_WIDTH]) ||
                (core_wen_i[0] != core_wen_i[1]) ||
                (core_be_i[BeWidth-1:0] != core_be_i[2*BeWidth-1:BeWidth])) begin
                mismatch = 1'b1;
            end
            // Write data only matters on writes (wen = 0).
            if (!core_wen_i[0] &&
                (core_wdata_i[DATA_WIDTH-1:0] != core_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH])) begin
                mismatch = 1'b1;
            end
        end
    end

    // Request and grant routing per mode; a full lane never issues.
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            full[l] = (cnt_q[l] == CntMax);
        end
        pair_go    = core_req_i[0] & core_req_i[1] & ~mismatch & ~full[0];
        ic_req_o   = '0;
        core_gnt_o = '0;
        case (state_q)
            StSplit: begin
                ic_req_o   = core_req_i & ~full;
                core_gnt_o = core_req_i & ~full & ic_gnt_i;
            end
            StLocked: begin
                ic_req_o[0] = pair_go;
                core_gnt_o  = {2{pair_go & ic_gnt_i[0]}};
            end
            default: ;
        endcase
    end

    // Outstanding counters; a response with nothing in flight is dropped.
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            inc[l]   = ic_req_o[l] & ic_gnt_i[l];
            dec[l]   = ic_r_valid_i[l] & (cnt_q[l] != '0);
            cnt_d[l] = cnt_q[l];
            if (inc[l] && !dec[l]) begin
                cnt_d[l] = cnt_q[l] + CntOne;
            end else if (!inc[l] && dec[l]) begin
                cnt_d[l] = cnt_q[l] - CntOne;
            end
        end
    end

    // Mode transitions, error counting and broadcast flag.
    always_comb begin
        state_d   = state_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            StSplit: begin
                if (lockstep_req_i) state_d = StDrain;
            end
            StDrain: begin
                if (cnt_d == '0) state_d = lockstep_req_i ? StLocked : StSplit;
            end
            StLocked: begin
                if (mismatch) begin
                    state_d = StFault;
                    if (err_cnt_q != ErrMax) err_cnt_d = err_cnt_q + ErrOne;
                end else if (!lockstep_req_i) begin
                    state_d = StDrain;
                end
            end
            StFault: begin
                if (fault_clr_i && (cnt_q == '0)) state_d = StSplit;
            end
            default: state_d = StSplit;
        endcase
        bcast_d = bcast_q;
        if (state_d == StLocked) begin
            bcast_d = 1'b1;
        end else if (state_d == StSplit) begin
            bcast_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StSplit;
            cnt_q     <= '0;
            bcast_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bcast_q   <= bcast_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Response delivery; under broadcast the checker sees the master lane.
    always_comb begin
        core_r_valid_o = ic_r_valid_i;
        core_r_rdata_o = ic_r_rdata_i;
        if (bcast_q) begin
            core_r_valid_o = {2{ic_r_valid_i[0]}};
            core_r_rdata_o = {2{ic_r_rdata_i[DATA_WIDTH-1:0]}};
        end
    end

    assign lockstep_active_o = (state_q == StLocked);
    assign fault_o           = (state_q == StFault);
    assign err_cnt_o         = err_cnt_q;

`ifndef SYNTHESIS
    for (genvar l = 0; l < 2; l++) begin : g_rvalid_chk
        assert property (@(posedge clk_i) disable iff (rst_i)
            !(ic_r_valid_i[l] && (cnt_q[l] == '0)));
    end
`endif

endmodule

// File: rtl/lockstep_tcdm_pair_ctrl.sv
// Core-to-TCDM shim pairing cores 2p/2p+1 for optional lockstep execution.
module lockstep_tcdm_pair_ctrl
    import lockstep_pkg::*;
#(
    parameter int unsigned N_CORES         = 8,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned ERR_CNT_WIDTH   = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [N_CORES/2-1:0]                  lockstep_req_i,
    input  logic [N_CORES/2-1:0]                  fault_clr_i,
    output logic [N_CORES/2-1:0]                  lockstep_active_o,
    output logic [N_CORES/2-1:0]                  fault_o,
    output logic [(N_CORES/2)*ERR_CNT_WIDTH-1:0]  err_cnt_o,
    input  logic [N_CORES-1:0]                    core_req_i,
    input  logic [N_CORES-1:0]                    core_wen_i,
    input  logic [N_CORES*ADDR_WIDTH-1:0]         core_add_i,
    input  logic [N_CORES*DATA_WIDTH-1:0]         core_wdata_i,
    input  logic [N_CORES*(DATA_WIDTH/8)-1:0]     core_be_i,
    output logic [N_CORES-1:0]                    core_gnt_o,
    output logic [N_CORES-1:0]                    core_r_valid_o,
    output logic [N_CORES*DATA_WIDTH-1:0]         core_r_rdata_o,
    output logic [N_CORES-1:0]                    ic_req_o,
    output logic [N_CORES-1:0]                    ic_wen_o,
    output logic [N_CORES*ADDR_WIDTH-1:0]         ic_add_o,
    output logic [N_CORES*DATA_WIDTH-1:0]         ic_wdata_o,
    output logic [N_CORES*(DATA_WIDTH/8)-1:0]     ic_be_o,
    input  logic [N_CORES-1:0]                    ic_gnt_i,
    input  logic [N_CORES-1:0]                    ic_r_valid_i,
    input  logic [N_CORES*DATA_WIDTH-1:0]         ic_r_rdata_i
);

    localparam int unsigned NPairs  = N_CORES / 2;
    localparam int unsigned BeWidth = DATA_WIDTH / 8;

    // Request payload always follows the lane's own core.
    assign ic_wen_o   = core_wen_i;
    assign ic_add_o   = core_add_i;
    assign ic_wdata_o = core_wdata_i;
    assign ic_be_o    = core_be_i;

    for (genvar p = 0; p < NPairs; p++) begin : g_pair
        lockstep_pair_ctrl #(
            .ADDR_WIDTH      (ADDR_WIDTH),
            .DATA_WIDTH      (DATA_WIDTH),
            .MAX_OUTSTANDING (MAX_OUTSTANDING),
            .ERR_CNT_WIDTH   (ERR_CNT_WIDTH)
        ) u_pair (
            .clk_i             (clk_i),
            .rst_i             (rst_i),
            .lockstep_req_i    (lockstep_req_i[p]),
            .fault_clr_i       (fault_clr_i[p]),
            .lockstep_active_o (lockstep_active_o[p]),
            .fault_o           (fault_o[p]),
            .err_cnt_o         (err_cnt_o[p*ERR_CNT_WIDTH +: ERR_CNT_WIDTH]),
            .core_req_i        (core_req_i[2*p +: 2]),
            .core_wen_i        (core_wen_i[2*p +: 2]),
            .core_add_i        (core_add_i[2*p*ADDR_WIDTH +: 2*ADDR_WIDTH]),
            .core_wdata_i      (core_wdata_i[2*p*DATA_WIDTH +: 2*DATA_WIDTH]),
            .core_be_i         (core_be_i[2*p*BeWidth +: 2*BeWidth]),
            .core_gnt_o        (core_gnt_o[2*p +: 2]),
            .core_r_valid_o    (core_r_valid_o[2*p +: 2]),
            .core_r_rdata_o    (core_r_rdata_o[2*p*DATA_WIDTH +: 2*DATA_WIDTH]),
            .ic_req_o          (ic_req_o[2*p +: 2]),
            .ic_gnt_i          (ic_gnt_i[2*p +: 2]),
            .ic_r_valid_i      (ic_r_valid_i[2*p +: 2]),
            .ic_r_rdata_i      (ic_r_rdata_i[2*p*DATA_WIDTH +: 2*DATA_WIDTH])
        );
    end

endmodule
